// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//   Receive-side inverse of a BCD-to-7-segment scanner. Samples a multiplexed
//   7-segment bus and debounces every digit dwell. Each accepted digit is
//   decoded back to BCD, and a complete display frame is offered to a
//   consumer over a valid/ready handshake.
//
// Parameters
//   NUM_DIGITS     digits per frame (1..8)
//   STABLE_CYCLES  identical consecutive samples needed to accept (>=2)
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   en           in   decoder enable; low clears the collect side
//   seg_in       in   [6:0] segments a..g on bits 6..0, active high
//   digit_sel    in   [NUM_DIGITS-1:0] one-hot digit strobe
//   bcd_out      out  [4*NUM_DIGITS-1:0] frame, digit i in [4i+3:4i]
//   frame_valid  out  bcd_out holds an unconsumed frame
//   frame_ready  in   consumer takes the frame when valid & ready
//   blank_mask   out  [NUM_DIGITS-1:0] digit i was blank in the frame
//   digit_err    out  one-cycle pulse, illegal pattern accepted
//   overrun      out  one-cycle pulse, completed frame dropped
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [6:0]                seg_in,
  input  logic [NUM_DIGITS-1:0]     digit_sel,
  output logic [4*NUM_DIGITS-1:0]   bcd_out,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [NUM_DIGITS-1:0]     blank_mask,
  output logic                      digit_err,
  output logic                      overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = NUM_DIGITS + 7;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;
  typedef enum logic {COL_IDLE = 1'b0, COL_COLLECT = 1'b1} col_state_t;

  // Returns {legal, blank, nibble}; all-dark segments decode to a legal blank.
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    logic [5:0] r;
    case (seg)
      7'h7E:   r = {1'b1, 1'b0, 4'h0};
      7'h30:   r = {1'b1, 1'b0, 4'h1};
      7'h6D:   r = {1'b1, 1'b0, 4'h2};
      7'h79:   r = {1'b1, 1'b0, 4'h3};
      7'h33:   r = {1'b1, 1'b0, 4'h4};
      7'h5B:   r = {1'b1, 1'b0, 4'h5};
      7'h5F:   r = {1'b1, 1'b0, 4'h6};
      7'h70:   r = {1'b1, 1'b0, 4'h7};
      7'h7F:   r = {1'b1, 1'b0, 4'h8};
      7'h7B:   r = {1'b1, 1'b0, 4'h9};
      7'h00:   r = {1'b1, 1'b1, 4'hF};
      default: r = 6'b00_0000;
    endcase
    return r;
  endfunction

  // Registered state
  logic [SW-1:0]           prev_q,        prev_d;
  logic [CW-1:0]           cnt_q,         cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q,      shadow_d;
  logic [NUM_DIGITS-1:0]   shadow_blk_q,  shadow_blk_d;
  logic [NUM_DIGITS-1:0]   seen_q,        seen_d;
  logic [4*NUM_DIGITS-1:0] bcd_out_q,     bcd_out_d;
  logic [NUM_DIGITS-1:0]   blank_mask_q,  blank_mask_d;
  logic                    digit_err_q,   digit_err_d;
  logic                    overrun_q,     overrun_d;
  out_state_t              out_state_q,   out_state_d;
  col_state_t              col_state_q,   col_state_d;

  // Combinational helpers
  logic [SW-1:0] sample_s;
  logic          one_hot_s;
  logic          same_s;
  logic [5:0]    dec_s;
  logic          accept_s;
  logic          frame_done_s;

  // Sample classification and the single accept strobe of a dwell.
  always_comb begin
    sample_s  = {digit_sel, seg_in};
    one_hot_s = (digit_sel != '0) &&
                ((digit_sel & (digit_sel - NUM_DIGITS'(1))) == '0);
    same_s    = (sample_s == prev_q);
    dec_s     = decode_seg(seg_in);
    // cnt crossing STABLE-1 -> STABLE happens only once per dwell because the
    // counter saturates; COLLECT is implied whenever cnt_q is non-zero.
    accept_s  = en && (col_state_q == COL_COLLECT) && one_hot_s && same_s &&
                (cnt_q == CNT_ACC);
  end

  // Next-state logic for the stability filter, frame assembly and output side.
  always_comb begin
    prev_d       = prev_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    shadow_blk_d = shadow_blk_q;
    seen_d       = seen_q;
    bcd_out_d    = bcd_out_q;
    blank_mask_d = blank_mask_q;
    digit_err_d  = 1'b0;
    overrun_d    = 1'b0;
    out_state_d  = out_state_q;
    col_state_d  = en ? COL_COLLECT : COL_IDLE;
    frame_done_s = 1'b0;

    if (en) begin
      prev_d = sample_s;
      if (one_hot_s) begin
        if (same_s) begin
          cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
        end else begin
          cnt_d = CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end else begin
      prev_d = '0;
      cnt_d  = '0;
      seen_d = '0;
    end

    if (accept_s) begin
      if (dec_s[5]) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (digit_sel[i]) begin
            shadow_d[4*i +: 4] = dec_s[3:0];
            shadow_blk_d[i]    = dec_s[4];
          end else begin
            shadow_d[4*i +: 4] = shadow_d[4*i +: 4];
          end
        end
        seen_d = seen_q | digit_sel;
        if (&seen_d) begin
          seen_d       = '0;
          frame_done_s = 1'b1;
        end else begin
          frame_done_s = 1'b0;
        end
      end else begin
        digit_err_d = 1'b1;
        seen_d      = '0;
      end
    end else begin
      frame_done_s = 1'b0;
    end

    // A new frame may load on the very edge the old one is consumed.
    if (frame_done_s && ((out_state_q == OUT_EMPTY) || frame_ready)) begin
      bcd_out_d    = shadow_d;
      blank_mask_d = shadow_blk_d;
      out_state_d  = OUT_FULL;
    end else if (frame_done_s) begin
      overrun_d = 1'b1;
    end else if ((out_state_q == OUT_FULL) && frame_ready) begin
      out_state_d = OUT_EMPTY;
    end else begin
      out_state_d = out_state_q;
    end
  end

  // State registers for both FSMs and all datapath flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      shadow_blk_q <= '0;
      seen_q       <= '0;
      bcd_out_q    <= '0;
      blank_mask_q <= '0;
      digit_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      out_state_q  <= OUT_EMPTY;
      col_state_q  <= COL_IDLE;
    end else begin
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      shadow_blk_q <= shadow_blk_d;
      seen_q       <= seen_d;
      bcd_out_q    <= bcd_out_d;
      blank_mask_q <= blank_mask_d;
      digit_err_q  <= digit_err_d;
      overrun_q    <= overrun_d;
      out_state_q  <= out_state_d;
      col_state_q  <= col_state_d;
    end
  end

  assign bcd_out     = bcd_out_q;
  assign blank_mask  = blank_mask_q;
  assign frame_valid = (out_state_q == OUT_FULL);
  assign digit_err   = digit_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder. Expected frames are pushed to a
// scoreboard queue when a scan is driven and popped when the DUT hands a
// frame over; pulse outputs are counted and compared at checkpoints.
module tb_seg7_scan_decoder;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [6:0]    seg_in;
  logic [ND-1:0] digit_sel;
  logic [15:0]   bcd_out;
  logic          frame_valid;
  logic          frame_ready;
  logic [ND-1:0] blank_mask;
  logic          digit_err;
  logic          overrun;

  int n_vec   = 0;
  int n_err   = 0;
  int n_frm   = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  logic [19:0] exp_q[$];

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .seg_in(seg_in),
    .digit_sel(digit_sel), .bcd_out(bcd_out), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .blank_mask(blank_mask),
    .digit_err(digit_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: a frame is consumed on the edge following a negedge
  // that sees valid & ready.
  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_valid && frame_ready) begin
        logic [19:0] e;
        check("sb_frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_bcd_out", 32'(bcd_out), 32'(e[15:0]));
          check("sb_blank_mask", 32'(blank_mask), 32'(e[19:16]));
          n_frm++;
        end
      end
      if (digit_err) err_cnt++;
      if (overrun)   ovr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_digit(input logic [ND-1:0] sel, input logic [6:0] seg, input int n);
    digit_sel = sel;
    seg_in    = seg;
    repeat (n) tick();
  endtask

  task automatic scan(input logic [6:0] s3, input logic [6:0] s2,
                      input logic [6:0] s1, input logic [6:0] s0);
    drive_digit(4'b1000, s3, 8);
    drive_digit(4'b0100, s2, 8);
    drive_digit(4'b0010, s1, 8);
    drive_digit(4'b0001, s0, 8);
    drive_digit(4'b0000, 7'h00, 2);
  endtask

  initial begin
    int f0;
    reset_n     = 1'b0;
    en          = 1'b1;
    frame_ready = 1'b1;
    seg_in      = 7'h00;
    digit_sel   = 4'b0000;

    // 1: reset with toggling inputs, then idle release
    for (int i = 0; i < 6; i++) begin
      digit_sel = 4'(1 << (i % 4));
      seg_in    = 7'($urandom_range(0, 127));
      tick();
    end
    check("rst_bcd_out", 32'(bcd_out), 32'h0);
    check("rst_blank_mask", 32'(blank_mask), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_digit_err", 32'(digit_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    digit_sel = 4'b0000;
    seg_in    = 7'h00;
    reset_n   = 1'b1;
    repeat (20) tick();
    check("idle_frame_valid", 32'(frame_valid), 32'h0);

    // 2: plain scan 1234
    exp_q.push_back({4'b0000, 16'h1234});
    scan(7'h30, 7'h6D, 7'h79, 7'h33);
    check("t2_frames", 32'(n_frm), 32'd1);
    check("t2_bcd_hold", 32'(bcd_out), 32'h1234);
    check("t2_valid_low", 32'(frame_valid), 32'h0);

    // 3: 3-cycle glitch on digit 2 after it was accepted is ignored
    exp_q.push_back({4'b0000, 16'h1234});
    drive_digit(4'b1000, 7'h30, 8);
    drive_digit(4'b0100, 7'h6D, 8);
    drive_digit(4'b0000, 7'h00, 1);
    drive_digit(4'b0100, 7'h7F, 3);
    drive_digit(4'b0010, 7'h79, 8);
    drive_digit(4'b0001, 7'h33, 8);
    drive_digit(4'b0000, 7'h00, 2);
    check("t3_frames", 32'(n_frm), 32'd2);

    // 4: illegal pattern aborts the frame, then blank-digit frame
    drive_digit(4'b1000, 7'h00, 8);
    drive_digit(4'b0100, 7'h01, 8);
    drive_digit(4'b0000, 7'h00, 2);
    check("t4_err_pulses", 32'(err_cnt), 32'd1);
    check("t4_no_frame", 32'(n_frm), 32'd2);
    check("t4_valid_low", 32'(frame_valid), 32'h0);
    exp_q.push_back({4'b1000, 16'hF111});
    scan(7'h00, 7'h30, 7'h30, 7'h30);
    check("t4_frames", 32'(n_frm), 32'd3);
    check("t4_mask_hold", 32'(blank_mask), 32'h8);

    // 5: consumer stalled across two scans -> second frame dropped
    frame_ready = 1'b0;
    exp_q.push_back({4'b0000, 16'h1234});
    scan(7'h30, 7'h6D, 7'h79, 7'h33);
    check("t5_valid_high", 32'(frame_valid), 32'h1);
    scan(7'h5B, 7'h5F, 7'h70, 7'h7F);
    check("t5_overrun", 32'(ovr_cnt), 32'd1);
    check("t5_bcd_kept", 32'(bcd_out), 32'h1234);
    check("t5_valid_held", 32'(frame_valid), 32'h1);
    frame_ready = 1'b1;
    tick();
    check("t5_valid_fall", 32'(frame_valid), 32'h0);
    check("t5_frames", 32'(n_frm), 32'd4);

    // 6a: reset after two digits discards progress
    drive_digit(4'b1000, 7'h5B, 8);
    drive_digit(4'b0100, 7'h5F, 8);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    f0 = n_frm;
    drive_digit(4'b0010, 7'h70, 8);
    drive_digit(4'b0001, 7'h7F, 8);
    drive_digit(4'b0000, 7'h00, 2);
    check("t6_rst_no_frame", 32'(n_frm - f0), 32'd0);
    en = 1'b0;
    tick();
    en = 1'b1;
    exp_q.push_back({4'b0000, 16'h5678});
    scan(7'h5B, 7'h5F, 7'h70, 7'h7F);
    check("t6_rst_frame", 32'(n_frm - f0), 32'd1);

    // 6b: en low mid-scan discards progress
    drive_digit(4'b1000, 7'h30, 8);
    drive_digit(4'b0100, 7'h6D, 8);
    en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    f0 = n_frm;
    drive_digit(4'b0010, 7'h79, 8);
    drive_digit(4'b0001, 7'h33, 8);
    drive_digit(4'b0000, 7'h00, 2);
    check("t6_en_no_frame", 32'(n_frm - f0), 32'd0);
    en = 1'b0;
    tick();
    en = 1'b1;
    exp_q.push_back({4'b0000, 16'h1234});
    scan(7'h30, 7'h6D, 7'h79, 7'h33);
    check("t6_en_frame", 32'(n_frm - f0), 32'd1);

    repeat (4) tick();
    check("end_sb_empty", 32'(exp_q.size()), 32'd0);
    check("end_err_total", 32'(err_cnt), 32'd1);
    check("end_ovr_total", 32'(ovr_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
